// File: rtl/cla_serial_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package cla_serial_seq_pkg;

  localparam int NIBW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_adder.sv
// 4-bit carry-lookahead adder: result[3:0] is the sum, result[4] the carry out.
module cla_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [4:0] result
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is flattened from generate/propagate terms rather than rippled.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign result = {c[4], p ^ c[3:0]};

endmodule

// File: rtl/cla_serial_seq.sv
// Time-multiplexes one 4-bit cla_adder over a WIDTH-bit add/subtract,
// LSB nibble first, with a registered carry between nibbles.
module cla_serial_seq
  import cla_serial_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB  = WIDTH / NIBW;
  localparam int IDXW = $clog2(NIB + 1);
  localparam int OFFW = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [OFFW-1:0]  bitOff;
  logic [4:0]       addRes;
  logic [WIDTH-1:0] accMerged;

  assign bitOff = OFFW'(int'(idx_q) * NIBW);

  cla_adder u_cla_adder (
    .a      (opA_q[bitOff +: NIBW]),
    .b      (opB_q[bitOff +: NIBW]),
    .cin    (carry_q),
    .result (addRes)
  );

  // Accumulator with the current nibble already folded in, so the final
  // RUN edge can publish the complete result straight into sum_q.
  always_comb begin
    accMerged = acc_q;
    accMerged[bitOff +: NIBW] = addRes[NIBW-1:0];
  end

  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          opA_d   = a;
          opB_d   = sub ? ~b : b;
          carry_d = cin ^ sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = accMerged;
        carry_d = addRes[NIBW];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          sum_d   = accMerged;
          cout_d  = addRes[NIBW];
          ovf_d   = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) && (accMerged[WIDTH-1] != opA_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_serial_seq.sv
// Self-checking bench for cla_serial_seq: directed table, corner sequences
// and random operations against an integer-arithmetic reference model.
module tb_cla_serial_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int compared = 0;
  int mismatched = 0;

  logic [W-1:0] prevSum = '0;
  logic         prevCout = 1'b0;
  logic         prevOvf = 1'b0;

  int           doneAt, doneCnt, busyCnt;
  bit           holdOk;
  logic [W-1:0] gotSum;
  logic         gotCout, gotOvf;

  typedef struct {
    logic         s;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         c;
    logic [W-1:0] expSum;
    logic         expCout;
    logic         expOvf;
  } vec_t;

  vec_t vecs[7];

  cla_serial_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference built from plain integer arithmetic on the operand values.
  task automatic refModel(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic c, output logic [W-1:0] rs, output logic rc, output logic ro);
    longint full, sgn;
    if (!s) begin
      full = longint'(av) + longint'(bv) + longint'(c);
      rc   = (full >= 65536);
      sgn  = longint'($signed(av)) + longint'($signed(bv)) + longint'(c);
    end else begin
      full = longint'(av) - longint'(bv) - longint'(c);
      rc   = (full >= 0);
      sgn  = longint'($signed(av)) - longint'($signed(bv)) - longint'(c);
    end
    rs = full[W-1:0];
    ro = (sgn > 32767) || (sgn < -32768);
  endtask

  // One handshake; optionally scrambles the inputs right after acceptance.
  task automatic applyStimulus(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic c, input bit scramble,
                               input logic [W-1:0] eS, input logic eC, input logic eO);
    @(negedge clk);
    start = 1'b1; sub = s; a = av; b = bv; cin = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (scramble) begin
      a = W'($urandom); b = W'($urandom); sub = ~s; cin = ~c;
    end
    doneAt = 0; doneCnt = 0; busyCnt = 0; holdOk = 1;
    gotSum = '0; gotCout = 1'b0; gotOvf = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (doneAt == 0) begin
          doneAt = i;
          gotSum = sum; gotCout = cout; gotOvf = ovf;
        end
      end
      if (doneAt == 0) begin
        if (sum !== prevSum || cout !== prevCout || ovf !== prevOvf) holdOk = 0;
      end else begin
        if (sum !== eS || cout !== eC || ovf !== eO) holdOk = 0;
      end
    end
    checkOutput("sum", 32'(gotSum), 32'(eS));
    checkOutput("cout", 32'(gotCout), 32'(eC));
    checkOutput("ovf", 32'(gotOvf), 32'(eO));
    checkOutput("done_latency", 32'(doneAt), 32'd5);
    checkOutput("done_count", 32'(doneCnt), 32'd1);
    checkOutput("busy_cycles", 32'(busyCnt), 32'd4);
    checkOutput("outputs_hold", 32'(holdOk), 32'd1);
    prevSum = eS; prevCout = eC; prevOvf = eO;
  endtask

  initial begin
    logic [W-1:0] rs, ra, rb;
    logic         rc, ro, rsb, rci;
    int           dones, lastDone, spacingOk, stray;

    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0};

    $display("[TB] reset");
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_sum", 32'(sum), 32'd0);
    checkOutput("reset_cout", 32'(cout), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    $display("[TB] directed table");
    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i].s, vecs[i].av, vecs[i].bv, vecs[i].c, (i % 2) == 1,
                    vecs[i].expSum, vecs[i].expCout, vecs[i].expOvf);

    $display("[TB] start held high");
    refModel(1'b0, 16'h0F0F, 16'h1111, 1'b1, rs, rc, ro);
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 16'h0F0F; b = 16'h1111; cin = 1'b1;
    dones = 0; lastDone = 0; spacingOk = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (lastDone != 0 && (i - lastDone) != 6) spacingOk = 0;
        lastDone = i;
      end
    end
    checkOutput("held_done_count", 32'(dones), 32'd3);
    checkOutput("held_spacing", 32'(spacingOk), 32'd1);
    checkOutput("held_sum", 32'(sum), 32'(rs));
    start = 1'b0;
    repeat (8) @(negedge clk);
    prevSum = rs; prevCout = rc; prevOvf = ro;

    $display("[TB] reset during run");
    applyStimulus(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 16'hAAAA; b = 16'h1111; cin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_sum", 32'(sum), 32'd0);
    checkOutput("midreset_cout", 32'(cout), 32'd0);
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    checkOutput("midreset_no_done", 32'(stray), 32'd0);
    prevSum = '0; prevCout = 1'b0; prevOvf = 1'b0;
    applyStimulus(1'b0, 16'hAAAA, 16'h1111, 1'b0, 1'b0, 16'hBBBB, 1'b0, 1'b0);

    $display("[TB] random operations");
    for (int i = 0; i < 24; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rsb = 1'($urandom_range(0, 1));
      rci = 1'($urandom_range(0, 1));
      refModel(rsb, ra, rb, rci, rs, rc, ro);
      applyStimulus(rsb, ra, rb, rci, $urandom_range(0, 1) == 1, rs, rc, ro);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cla_serial_seq.md
# cla_serial_seq

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing the existing 4-bit `cla_adder` one nibble per cycle, LSB nibble first, with a registered ripple carry between nibbles. It sits between the switch/control front end and the seven-segment display path. It accepts one operation per start/done handshake and holds the registered result for display until the next operation.

## Interface
- `WIDTH`, 16, operand width; multiple of 4, ≥ 4.
- `NIB`, WIDTH/4, nibble count (derived localparam, not overridable).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `sub`  in  1  0 = A+B+cin; 1 = A−B−cin (borrow-in).
- `a`  in  WIDTH  operand A, captured at accepted start.
- `b`  in  WIDTH  operand B, captured at accepted start.
- `cin`  in  1  carry-in (add) or borrow-in (sub), captured at accepted start.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `sum`  out  WIDTH  registered result.
- `cout`  out  1  final carry (sub: 1 = no borrow).
- `ovf`  out  1  signed two's-complement overflow.

## Operation
- **Reset:** one clock only, synchronous, active-low; no asynchronous path. State → IDLE; `busy`, `done`, `sum`, `cout`, `ovf`, nibble index, carry register and operand registers all 0.
- **IDLE:**
  - `start`=1 captures `a` → A_r and (`sub` ? ~`b` : `b`) → B_r.
  - Carry register ← `cin` ^ `sub`.
  - Nibble index k ← 0; → RUN.
- **RUN (k = 0..NIB−1):**
  - `cla_adder` inputs: A_r[4k+3:4k], B_r[4k+3:4k], carry register.
  - Result bits [3:0] → accumulator nibble k; bit 4 → carry register.
  - k increments each cycle.
  - At k = NIB−1 → DONE.
- **DONE:**
  - `sum` ← accumulator; `cout` ← final carry.
  - `ovf` ← (A_r[MSB] == B_r[MSB]) && (sum[MSB] != A_r[MSB]), with B_r the inverted operand when `sub`.
  - `done`=1 for exactly this cycle; → IDLE unconditionally.
- **Outputs:** `sum`, `cout` and `ovf` change only on entry to DONE or on reset; they hold between operations.
- **`start` outside IDLE:** ignored (RUN and DONE). If held high continuously, it is accepted in the IDLE cycle after DONE.
- **Input changes:** changes to `a`, `b`, `sub` or `cin` after acceptance have no effect on the operation in flight.
- **Reset mid-RUN:** abandons the operation; no `done` pulse; registered outputs clear to 0.
- **Width rules:** arithmetic is modulo 2^WIDTH; the carry out of nibble NIB−1 is `cout`.

## Timing
- Acceptance edge E0 (IDLE, `start`=1).
- `busy`=1 from the cycle after E0 through E0+NIB; the nibbles are computed on edges E0+1 … E0+NIB.
- `done`=1 and results valid in the cycle after edge E0+NIB. For WIDTH=16, `done` is high 5 cycles after E0.
- Throughput: one operation per NIB+2 cycles (IDLE, NIB×RUN, DONE).
- The only combinational path is register → `cla_adder` → register. No output is combinational from inputs.

## Structure
- Shared package/header holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - nibble width constant 4.
- One sub-module, instantiated once: the existing `cla_adder`.
  - Inputs: 4-bit a, 4-bit b, 1-bit cin.
  - Output: result with sum in [3:0] and carry-out in bit 4.
- Nibble select and accumulator write use an indexed part-select on k. Shift registers are not required.

## Test plan
- WIDTH=16, add 0x1234 + 0x4321, cin=0 → `sum`=0x5555, `cout`=0, `ovf`=0; `done` pulses exactly once, 5 cycles after acceptance; `busy` high 4 cycles.
- Add 0xFFFF + 0x0001, cin=0 → `sum`=0x0000, `cout`=1, `ovf`=0 (carry ripples through all 4 nibbles).
- Add 0x7FFF + 0x0001 → `sum`=0x8000, `cout`=0, `ovf`=1. Sub 0x8000 − 0x0001 → `sum`=0x7FFF, `ovf`=1.
- Sub 0x0005 − 0x0007, cin=0 → `sum`=0xFFFE, `cout`=0. Sub with cin=1 (borrow-in), 0x0005 − 0x0003 → `sum`=0x0001, `cout`=1.
- `start` held high for 20 cycles with fixed operands → exactly one `done` per 6-cycle frame. Operands changed during RUN → result reflects the captured values.
- `rst_n`=0 on the second RUN cycle → next edge: IDLE, all outputs 0, no `done`; a `start` on the following cycle completes normally with correct `sum`.
